// File: rtl/nonlinear_pkg.sv
// ---------------------------------------------------------------------------
// nonlinear_pkg
// Shared types for the nonlinear unit command path.
//   op_e      : 4-bit operation code carried to the controller
//   nl_cmd_t  : decoded command fields as held in the FIFO / output register
//   err_e     : cause of an illegal instruction word being dropped
//   *_MSB/LSB : bit positions of each field in the 64-bit instruction word
//   is_legal_op() : true for the implemented operation codes
// ---------------------------------------------------------------------------
package nonlinear_pkg;

    localparam int OP_MSB    = 63;
    localparam int OP_LSB    = 60;
    localparam int BUB_MSB   = 59;
    localparam int BUB_LSB   = 56;
    localparam int CONT_MSB  = 55;
    localparam int CONT_LSB  = 54;
    localparam int DLEN_MSB  = 53;
    localparam int DLEN_LSB  = 44;
    localparam int DADDR_MSB = 43;
    localparam int DADDR_LSB = 28;
    localparam int WLEN_MSB  = 27;
    localparam int WLEN_LSB  = 24;
    localparam int WADDR_MSB = 23;
    localparam int WADDR_LSB = 18;
    localparam int OADDR_MSB = 17;
    localparam int OADDR_LSB = 2;
    localparam int RSVD_MSB  = 1;
    localparam int RSVD_LSB  = 0;

    typedef enum logic [3:0] {
        OP_SOFTMAX     = 4'd0,
        OP_SIGMOID     = 4'd1,
        OP_TANH        = 4'd2,
        OP_RELU        = 4'd3,
        OP_POOLING     = 4'd4,
        OP_AVG_POOLING = 4'd5
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [3:0]  bubble;
        logic [1:0]  continuity;
        logic [9:0]  din_length;
        logic [15:0] din_addr;
        logic [3:0]  win_length;
        logic [5:0]  win_addr;
        logic [15:0] dout_addr;
    } nl_cmd_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BAD_OP   = 2'd1,
        ERR_ZERO_LEN = 2'd2,
        ERR_RSVD     = 2'd3
    } err_e;

    // Codes above average_pooling are unimplemented and must be dropped.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= 4'd5);
    endfunction

endpackage

// File: rtl/nonlinear_cmd_fifo.sv
// ---------------------------------------------------------------------------
// nonlinear_cmd_fifo
// Synchronous FIFO of decoded nl_cmd_t commands.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : synchronous clear of all entries
//   i_push, i_data : write one command (ignored when full)
//   i_pop          : remove the head command (ignored when empty)
//   o_data         : head command (valid when !o_empty)
//   o_full, o_empty, o_count : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module nonlinear_cmd_fifo
    import nonlinear_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  nl_cmd_t                  i_data,
    input  logic                     i_pop,
    output nl_cmd_t                  o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    nl_cmd_t         r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nonlinear_cmd_decode.sv
// ---------------------------------------------------------------------------
// nonlinear_cmd_decode
// Issue stage in front of the nonlinear unit controller. Accepts packed
// 64-bit instruction words, validates them, buffers legal commands and
// presents them one at a time on a registered valid/ready interface.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_instr_valid/o_instr_ready/i_instr_data : instruction word input
//   i_flush                 : synchronous clear of buffered and pending commands
//   o_nl_valid/i_nl_ready   : command handshake toward the controller
//   o_nl_*                  : registered command fields
//   o_err_pulse             : one-cycle pulse when an illegal word is dropped
//   o_err_code              : cause of the most recent drop (err_e)
//   o_err_cnt               : saturating count of dropped words
//   o_idle                  : nothing buffered and no command presented
// ---------------------------------------------------------------------------
module nonlinear_cmd_decode
    import nonlinear_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    input  logic [63:0]       i_instr_data,
    input  logic              i_flush,
    output logic              o_nl_valid,
    input  logic              i_nl_ready,
    output logic [3:0]        o_nl_op,
    output logic [3:0]        o_nl_bubble,
    output logic [1:0]        o_nl_continuity,
    output logic [9:0]        o_nl_din_length,
    output logic [15:0]       o_nl_din_addr,
    output logic [3:0]        o_nl_win_length,
    output logic [5:0]        o_nl_win_addr,
    output logic [15:0]       o_nl_dout_addr,
    output logic              o_err_pulse,
    output logic [1:0]        o_err_code,
    output logic [ERR_W-1:0]  o_err_cnt,
    output logic              o_idle
);

    nl_cmd_t                 w_cmd;
    nl_cmd_t                 w_head;
    err_e                    w_err;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_load;
    logic                    w_full;
    logic                    w_empty;
    logic [$clog2(DEPTH):0]  w_count;

    nl_cmd_t                 r_cmd;
    logic                    r_nl_valid;
    logic                    r_err_pulse;
    err_e                    r_err_code;
    logic [ERR_W-1:0]        r_err_cnt;

    // Ready depends only on registered occupancy, so a pop in the same
    // cycle cannot open a slot; flush and reset force it low.
    assign o_instr_ready = i_rst_n & ~w_full & ~i_flush;
    assign w_accept      = i_instr_valid & o_instr_ready;
    assign w_push        = w_accept & (w_err == ERR_NONE);

    assign w_cmd.op         = op_e'(i_instr_data[OP_MSB:OP_LSB]);
    assign w_cmd.bubble     = i_instr_data[BUB_MSB:BUB_LSB];
    assign w_cmd.continuity = i_instr_data[CONT_MSB:CONT_LSB];
    assign w_cmd.din_length = i_instr_data[DLEN_MSB:DLEN_LSB];
    assign w_cmd.din_addr   = i_instr_data[DADDR_MSB:DADDR_LSB];
    assign w_cmd.win_length = i_instr_data[WLEN_MSB:WLEN_LSB];
    assign w_cmd.win_addr   = i_instr_data[WADDR_MSB:WADDR_LSB];
    assign w_cmd.dout_addr  = i_instr_data[OADDR_MSB:OADDR_LSB];

    // Checks in priority order; only the first failing cause is reported.
    always_comb begin
        w_err = ERR_NONE;
        if (!is_legal_op(i_instr_data[OP_MSB:OP_LSB])) begin
            w_err = ERR_BAD_OP;
        end else if (i_instr_data[DLEN_MSB:DLEN_LSB] == '0) begin
            w_err = ERR_ZERO_LEN;
        end else if (i_instr_data[RSVD_MSB:RSVD_LSB] != '0) begin
            w_err = ERR_RSVD;
        end
    end

    nonlinear_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_push  (w_push),
        .i_data  (w_cmd),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // The output register refills whenever it is empty or being consumed,
    // giving one command per cycle under continuous ready.
    assign w_load = ~r_nl_valid | i_nl_ready;
    assign w_pop  = w_load & ~w_empty & ~i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_nl_valid <= 1'b0;
            r_cmd      <= '0;
        end else if (i_flush) begin
            r_nl_valid <= 1'b0;
        end else if (w_load) begin
            r_nl_valid <= ~w_empty;
            if (!w_empty) begin
                r_cmd <= w_head;
            end
        end
    end

    // Error reporting survives flush; only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_pulse <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_cnt   <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (w_accept && (w_err != ERR_NONE)) begin
                r_err_pulse <= 1'b1;
                r_err_code  <= w_err;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

    assign o_nl_valid      = r_nl_valid;
    assign o_nl_op         = r_cmd.op;
    assign o_nl_bubble     = r_cmd.bubble;
    assign o_nl_continuity = r_cmd.continuity;
    assign o_nl_din_length = r_cmd.din_length;
    assign o_nl_din_addr   = r_cmd.din_addr;
    assign o_nl_win_length = r_cmd.win_length;
    assign o_nl_win_addr   = r_cmd.win_addr;
    assign o_nl_dout_addr  = r_cmd.dout_addr;
    assign o_err_pulse     = r_err_pulse;
    assign o_err_code      = r_err_code;
    assign o_err_cnt       = r_err_cnt;
    assign o_idle          = (w_count == '0) & ~r_nl_valid;

endmodule

// File: tb/tb_nonlinear_cmd_decode.sv
module tb_nonlinear_cmd_decode;
   import nonlinear_pkg::*;

   localparam int DEPTH = 4;
   localparam int ERR_W = 8;

   logic        clock;
   logic        rstN;
   logic        instrValid;
   logic        instrReady;
   logic [63:0] instrData;
   logic        flush;
   logic        nlValid;
   logic        nlReady;
   logic [3:0]  nlOp;
   logic [3:0]  nlBubble;
   logic [1:0]  nlContinuity;
   logic [9:0]  nlDinLength;
   logic [15:0] nlDinAddr;
   logic [3:0]  nlWinLength;
   logic [5:0]  nlWinAddr;
   logic [15:0] nlDoutAddr;
   logic        errPulse;
   logic [1:0]  errCode;
   logic [7:0]  errCnt;
   logic        idle;

   int          errors = 0;
   int          checks = 0;

   // Scoreboard: every command the decoder still owes the controller, head
   // first. When expValid is set the head is the one in the output register.
   nl_cmd_t     q[$];
   logic        expValid = 1'b0;
   logic [1:0]  expCode  = 2'd0;
   logic [7:0]  expCnt   = 8'd0;

   nonlinear_cmd_decode #(
      .DEPTH (DEPTH),
      .ERR_W (ERR_W)
   ) dut (
      .i_clk           (clock),
      .i_rst_n         (rstN),
      .i_instr_valid   (instrValid),
      .o_instr_ready   (instrReady),
      .i_instr_data    (instrData),
      .i_flush         (flush),
      .o_nl_valid      (nlValid),
      .i_nl_ready      (nlReady),
      .o_nl_op         (nlOp),
      .o_nl_bubble     (nlBubble),
      .o_nl_continuity (nlContinuity),
      .o_nl_din_length (nlDinLength),
      .o_nl_din_addr   (nlDinAddr),
      .o_nl_win_length (nlWinLength),
      .o_nl_win_addr   (nlWinAddr),
      .o_nl_dout_addr  (nlDoutAddr),
      .o_err_pulse     (errPulse),
      .o_err_code      (errCode),
      .o_err_cnt       (errCnt),
      .o_idle          (idle)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pack an instruction word from its fields.
   function automatic logic [63:0] mkWord(input logic [3:0] op, input logic [3:0] bub,
                                          input logic [1:0] cont, input logic [9:0] dlen,
                                          input logic [15:0] daddr, input logic [3:0] wlen,
                                          input logic [5:0] waddr, input logic [15:0] oaddr,
                                          input logic [1:0] rsvd);
      return {op, bub, cont, dlen, daddr, wlen, waddr, oaddr, rsvd};
   endfunction

   // Reference legality check: 0 legal, else the drop cause.
   function automatic logic [1:0] modelCode(input logic [63:0] w);
      if (w[63:60] > 4'd5) return 2'd1;
      if (w[53:44] == 10'd0) return 2'd2;
      if (w[1:0] != 2'd0) return 2'd3;
      return 2'd0;
   endfunction

   // Reference field extraction.
   function automatic nl_cmd_t modelDecode(input logic [63:0] w);
      nl_cmd_t c;
      c.op         = op_e'(w[63:60]);
      c.bubble     = w[59:56];
      c.continuity = w[55:54];
      c.din_length = w[53:44];
      c.din_addr   = w[43:28];
      c.win_length = w[27:24];
      c.win_addr   = w[23:18];
      c.dout_addr  = w[17:2];
      return c;
   endfunction

   // One comparison: count it, and report tag/observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, compare the presented state against the
   // model, advance the model across the rising edge, then check the error
   // outputs that edge produced. Called just after a falling edge.
   task automatic applyStimulus(input logic v, input logic [63:0] d, input logic f, input logic r);
      int         fifoCnt;
      logic       expReady;
      logic [1:0] code;
      logic       illegalNow;
      nl_cmd_t    obsCmd;
      instrValid = v;
      instrData  = d;
      flush      = f;
      nlReady    = r;
      #1;
      fifoCnt  = q.size() - (expValid ? 1 : 0);
      expReady = (fifoCnt < DEPTH) && !f;
      checkOutput("instr_ready", 64'(instrReady), 64'(expReady));
      checkOutput("nl_valid", 64'(nlValid), 64'(expValid));
      checkOutput("idle", 64'(idle), 64'(!expValid && (q.size() == 0)));
      if (expValid && (q.size() > 0)) begin
         obsCmd = {nlOp, nlBubble, nlContinuity, nlDinLength, nlDinAddr,
                   nlWinLength, nlWinAddr, nlDoutAddr};
         checkOutput("nl_cmd", 64'(obsCmd), 64'(q[0]));
      end
      illegalNow = 1'b0;
      if (f) begin
         q.delete();
         expValid = 1'b0;
      end else begin
         if (!expValid || r) begin
            if (expValid) void'(q.pop_front());
            expValid = (fifoCnt > 0);
         end
         if (v && expReady) begin
            code = modelCode(d);
            if (code == 2'd0) begin
               q.push_back(modelDecode(d));
            end else begin
               illegalNow = 1'b1;
               expCode    = code;
               if (expCnt != 8'hFF) expCnt = expCnt + 8'd1;
            end
         end
      end
      @(posedge clock);
      @(negedge clock);
      checkOutput("err_pulse", 64'(errPulse), 64'(illegalNow));
      checkOutput("err_code", 64'(errCode), 64'(expCode));
      checkOutput("err_cnt", 64'(errCnt), 64'(expCnt));
   endtask

   // Directed sequence: reset, single command, backpressure, illegal words,
   // counter saturation, flush, asynchronous reset.
   initial begin
      logic [63:0] relu;
      logic [63:0] badOp;
      rstN       = 1'b0;
      instrValid = 1'b0;
      instrData  = '0;
      flush      = 1'b0;
      nlReady    = 1'b0;
      relu  = mkWord(4'd3, 4'd0, 2'd0, 10'd10, 16'h0100, 4'd3, 6'd0, 16'h2000, 2'd0);
      badOp = mkWord(4'd15, 4'd1, 2'd1, 10'd5, 16'h1111, 4'd2, 6'd3, 16'h3333, 2'd0);

      #12;
      $display("[TB] reset state");
      checkOutput("rst_nl_valid", 64'(nlValid), 64'd0);
      checkOutput("rst_fields", 64'({nlOp, nlBubble, nlContinuity, nlDinLength, nlDinAddr,
                                     nlWinLength, nlWinAddr, nlDoutAddr}), 64'd0);
      checkOutput("rst_instr_ready", 64'(instrReady), 64'd0);
      checkOutput("rst_err", 64'({errPulse, errCode, errCnt}), 64'd0);
      checkOutput("rst_idle", 64'(idle), 64'd1);
      rstN = 1'b1;
      #1;
      checkOutput("ready_after_rst", 64'(instrReady), 64'd1);

      $display("[TB] single command");
      applyStimulus(1'b1, relu, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("single_latency", 64'(nlValid), 64'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("single_idle", 64'(idle), 64'd1);

      $display("[TB] backpressure");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, mkWord(4'(i % 6), 4'(i), 2'(i), 10'(i + 1), 16'(16'h1000 + i),
                                    4'(i + 2), 6'(i * 3), 16'(16'hA000 + i), 2'd0), 1'b0, 1'b0);
      end
      checkOutput("bp_ready_low", 64'(instrReady), 64'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, relu, 1'b0, 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
         checkOutput("drain_valid", 64'(nlValid), 64'd1);
         applyStimulus(1'b0, '0, 1'b0, 1'b1);
      end
      checkOutput("drain_idle", 64'(idle), 64'd1);

      $display("[TB] illegal words");
      applyStimulus(1'b1, mkWord(4'd7, 4'd0, 2'd0, 10'd4, 16'h0, 4'd0, 6'd0, 16'h0, 2'd0), 1'b0, 1'b1);
      applyStimulus(1'b1, mkWord(4'd0, 4'd0, 2'd0, 10'd0, 16'h0, 4'd0, 6'd0, 16'h0, 2'd0), 1'b0, 1'b1);
      applyStimulus(1'b1, mkWord(4'd1, 4'd0, 2'd0, 10'd4, 16'h0, 4'd0, 6'd0, 16'h0, 2'b01), 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("illegal_cnt", 64'(errCnt), 64'd3);

      $display("[TB] error counter saturation");
      for (int i = 0; i < 260; i++) begin
         applyStimulus(1'b1, badOp, 1'b0, 1'b1);
      end
      checkOutput("sat_cnt", 64'(errCnt), 64'hFF);

      $display("[TB] flush");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, mkWord(4'd2, 4'd0, 2'd1, 10'(20 + i), 16'(16'h0200 + i),
                                    4'd1, 6'd7, 16'(16'h4000 + i), 2'd0), 1'b0, 1'b0);
      end
      applyStimulus(1'b1, relu, 1'b1, 1'b0);
      checkOutput("flush_valid", 64'(nlValid), 64'd0);
      checkOutput("flush_idle", 64'(idle), 64'd1);
      checkOutput("flush_keeps_cnt", 64'(errCnt), 64'hFF);
      applyStimulus(1'b1, mkWord(4'd5, 4'd9, 2'd3, 10'd1023, 16'hFFFF, 4'd15, 6'd63, 16'hFFFF, 2'd0),
                    1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);

      $display("[TB] async reset");
      applyStimulus(1'b1, relu, 1'b0, 1'b0);
      applyStimulus(1'b1, relu, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("pre_rst_valid", 64'(nlValid), 64'd1);
      #1 rstN = 1'b0;
      #1;
      checkOutput("async_valid", 64'(nlValid), 64'd0);
      checkOutput("async_ready", 64'(instrReady), 64'd0);
      checkOutput("async_err_cnt", 64'(errCnt), 64'd0);
      checkOutput("async_idle", 64'(idle), 64'd1);
      q.delete();
      expValid = 1'b0;
      expCnt   = 8'd0;
      expCode  = 2'd0;
      #1 rstN = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b1, relu, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
